// File: rtl/mac_dot_product_pkg.sv
// Shared constants and parameter sanity checks for the dot-product MAC.
package mac_dot_product_pkg;

  localparam int MAC_LATENCY = 4;

  // Parameter legality for the DSP48E1 mapping and the narrowing stage.
  function automatic bit widths_ok(input int a_w, input int b_w, input int acc_w,
                                   input int out_w, input int out_sh);
    return (a_w >= 2) && (a_w <= 25) && (b_w >= 2) && (b_w <= 18) &&
           (acc_w >= a_w + b_w) && (out_sh >= 0) && (out_w >= 2) &&
           (out_w <= acc_w - out_sh);
  endfunction

endpackage

// File: rtl/mac_dot_product_if.sv
// Sample-stream and result bus of the dot-product MAC.
interface mac_dot_product_if #(
  parameter int A_DATA_WIDTH = 25,
  parameter int B_DATA_WIDTH = 18,
  parameter int ACC_WIDTH    = 48,
  parameter int OUT_WIDTH    = 24,
  parameter int LEN_WIDTH    = 10
);
  logic [LEN_WIDTH-1:0]           len;
  logic                           clear;
  logic                           in_valid;
  logic signed [A_DATA_WIDTH-1:0] a;
  logic signed [B_DATA_WIDTH-1:0] b;
  logic                           out_valid;
  logic signed [OUT_WIDTH-1:0]    out_data;
  logic signed [ACC_WIDTH-1:0]    out_acc;
  logic                           out_sat;
  logic                           busy;

  modport master (
    output len, clear, in_valid, a, b,
    input  out_valid, out_data, out_acc, out_sat, busy
  );

  modport slave (
    input  len, clear, in_valid, a, b,
    output out_valid, out_data, out_acc, out_sat, busy
  );
endinterface

// File: rtl/mac_dot_product_round_saturate.sv
// Combinational round-half-up shift and signed clamp of the accumulator.
module round_saturate #(
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 24,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic                        sat,
  output logic signed [OUT_WIDTH-1:0] data
);
  localparam int W = ACC_WIDTH + 1;
  localparam logic signed [W-1:0] ONE   = W'(1);
  localparam logic signed [W-1:0] RND   = (OUT_SHIFT > 0) ?
                                          (ONE <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : W'(0);
  localparam logic signed [W-1:0] MAX_V = (ONE <<< (OUT_WIDTH - 1)) - ONE;
  localparam logic signed [W-1:0] MIN_V = ~MAX_V;

  logic signed [W-1:0] sum_s;
  logic signed [W-1:0] r_s;

  // One extra bit keeps the rounding increment from overflowing.
  always_comb begin
    sum_s = W'(acc) + RND;
    r_s   = sum_s >>> OUT_SHIFT;
    if (r_s > MAX_V) begin
      sat  = 1'b1;
      data = MAX_V[OUT_WIDTH-1:0];
    end else if (r_s < MIN_V) begin
      sat  = 1'b1;
      data = MIN_V[OUT_WIDTH-1:0];
    end else begin
      sat  = 1'b0;
      data = r_s[OUT_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/mac_dot_product.sv
// Four-stage signed MAC producing runtime-length dot products with
// automatic accumulator reload and rounded/saturated output.
module mac_dot_product
  import mac_dot_product_pkg::*;
#(
  parameter int A_DATA_WIDTH = 25,
  parameter int B_DATA_WIDTH = 18,
  parameter int ACC_WIDTH    = 48,
  parameter int OUT_WIDTH    = 24,
  parameter int OUT_SHIFT    = 0,
  parameter int LEN_WIDTH    = 10
) (
  input logic             clk,
  input logic             rst_n,
  mac_dot_product_if.slave bus
);
  localparam int PW = A_DATA_WIDTH + B_DATA_WIDTH;

  if (!widths_ok(A_DATA_WIDTH, B_DATA_WIDTH, ACC_WIDTH, OUT_WIDTH, OUT_SHIFT)) begin : g_bad_params
    $error("mac_dot_product: illegal width parameters");
  end

  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, eff_len_s;
  logic                 first_s, last_s, take_s;
  logic                 s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic signed [A_DATA_WIDTH-1:0] a_q, a_d;
  logic signed [B_DATA_WIDTH-1:0] b_q, b_d;
  logic signed [PW-1:0]           mul_s;
  logic                 s2_valid_q, s2_valid_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic signed [ACC_WIDTH-1:0]    prod_q, prod_d, acc_q, acc_d;
  logic                 s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
  logic                 out_valid_q, out_valid_d, out_sat_q, out_sat_d, busy_q, busy_d;
  logic signed [OUT_WIDTH-1:0]    out_data_q, out_data_d, rs_data_s;
  logic signed [ACC_WIDTH-1:0]    out_acc_q, out_acc_d;
  logic                           rs_sat_s;

  round_saturate #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_saturate (
    .acc  (acc_q),
    .sat  (rs_sat_s),
    .data (rs_data_s)
  );

  // Next-state logic for sequencing, pipeline stages and output register.
  always_comb begin
    first_s   = (cnt_q == '0);
    if (first_s) begin
      eff_len_s = (bus.len == '0) ? LEN_WIDTH'(1) : bus.len;
    end else begin
      eff_len_s = len_q;
    end
    last_s = (cnt_q == eff_len_s - LEN_WIDTH'(1));
    take_s = bus.in_valid & ~bus.clear;

    cnt_d = cnt_q;
    len_d = len_q;
    if (bus.clear) begin
      cnt_d = '0;
    end else if (take_s) begin
      cnt_d = last_s ? '0 : cnt_q + LEN_WIDTH'(1);
      len_d = first_s ? eff_len_s : len_q;
    end else begin
      cnt_d = cnt_q;
    end

    s1_valid_d = take_s;
    if (take_s) begin
      a_d        = bus.a;
      b_d        = bus.b;
      s1_first_d = first_s;
      s1_last_d  = last_s;
    end else begin
      a_d        = a_q;
      b_d        = b_q;
      s1_first_d = s1_first_q;
      s1_last_d  = s1_last_q;
    end

    mul_s      = PW'(a_q) * PW'(b_q);
    s2_valid_d = s1_valid_q & ~bus.clear;
    if (s1_valid_q) begin
      prod_d     = ACC_WIDTH'(mul_s);
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
    end else begin
      prod_d     = prod_q;
      s2_first_d = s2_first_q;
      s2_last_d  = s2_last_q;
    end

    // A first sample reloads rather than adds, so sequences never leak.
    s3_valid_d = s2_valid_q & ~bus.clear;
    if (s3_valid_d) begin
      acc_d     = s2_first_q ? prod_q : acc_q + prod_q;
      s3_last_d = s2_last_q;
    end else begin
      acc_d     = acc_q;
      s3_last_d = s3_last_q;
    end

    out_valid_d = s3_valid_q & s3_last_q & ~bus.clear;
    if (out_valid_d) begin
      out_data_d = rs_data_s;
      out_acc_d  = acc_q;
      out_sat_d  = rs_sat_s;
    end else begin
      out_data_d = out_data_q;
      out_acc_d  = out_acc_q;
      out_sat_d  = out_sat_q;
    end

    busy_d = (cnt_d != '0) | s1_valid_d | s2_valid_d | s3_valid_d | out_valid_d;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      len_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      prod_q      <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
      out_sat_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      prod_q      <= prod_d;
      s3_valid_q  <= s3_valid_d;
      s3_last_q   <= s3_last_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_acc_q   <= out_acc_d;
      out_sat_q   <= out_sat_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.busy      = busy_q;
endmodule
